coin_dispenser: RTL
===================

Name: coin_dispenser

Overview:
- Change-return counterpart to the vending datapath's coin accumulator. The accumulator turns quarter/dime/nickel pulses into a 10-bit cents total; this block turns a 10-bit cents amount back into individual coin-eject commands.
- Greedy selection (largest coin first), limited by on-board per-denomination stock.
- Handshakes each coin with the eject mechanism.
- Reports any amount it could not pay out.

Parameters:
- QUARTER_VALUE, 25, cents per quarter
- DIME_VALUE, 10, cents per dime
- NICKEL_VALUE, 5, cents per nickel
- STOCK_W, 8, width of each per-denomination stock counter

Ports:
- clk  input  1  system clock, all state changes on rising edge
- rst  input  1  reset, asynchronous, active-low
- start  input  1  request payout of amount; honoured only in IDLE
- amount  input  10  cents to pay out, sampled on accepted start
- restock  input  1  load stock counters; honoured only in IDLE
- stockQ_in, stockD_in, stockN_in  input  STOCK_W each  restock values
- coin_ack  input  1  eject mechanism has taken the presented coin
- outQ, outD, outN  output  1 each  eject command, level, held until coin_ack
- busy  output  1  high whenever state is not IDLE
- done  output  1  one-cycle pulse at end of payout
- shortfall  output  10  cents not paid; valid from done until next accepted start
- stockQ, stockD, stockN  output  STOCK_W each  current stock counts

Behaviour:
- Reset (rst low, asynchronous): state IDLE; all stock counters 0; remaining 0; shortfall 0; outQ/outD/outN 0; done 0; busy 0.
- States: IDLE, SELECT, EJECT, FINISH.
- IDLE:
  - restock=1 loads all three stock counters.
  - start=1 latches amount into a 10-bit remaining register and moves to SELECT.
  - If restock and start occur in the same cycle, both take effect; SELECT sees the new stock.
  - coin_ack is ignored.
- SELECT, priority order:
  - remaining>=QUARTER_VALUE and stockQ>0: choose Q.
  - else remaining>=DIME_VALUE and stockD>0: choose D.
  - else remaining>=NICKEL_VALUE and stockN>0: choose N.
  - A choice moves to EJECT and registers exactly one of outQ/outD/outN high.
  - No choice: go to FINISH.
- EJECT:
  - The selected out* line stays high until coin_ack=1 is sampled.
  - On that edge: out* drops; remaining is reduced by the coin value; the matching stock is decremented; go to SELECT.
  - coin_ack may arrive in the first EJECT cycle.
  - No timeout.
- FINISH: shortfall<=remaining; done=1 for exactly this cycle; return to IDLE.
- Timing:
  - start accepted at edge 0 puts SELECT in cycle 1 and the first out* high in cycle 2.
  - Each coin costs one SELECT cycle plus the EJECT cycles until ack.
  - amount=0: done in cycle 2 with shortfall 0.
- At most one of outQ/outD/outN is high in any cycle.
- start and restock while busy: ignored, no effect.
- Greedy is final even when a non-greedy mix would succeed. The resulting unpaid amount goes to shortfall.
- Remainders below NICKEL_VALUE (amount not a multiple of 5) are reported in shortfall.
- Stock never decrements below 0; the SELECT guard prevents it.
- Subtraction never underflows; the SELECT guard prevents it.
- Reset mid-payout:
  - Aborts the payout immediately.
  - All out* lines drop asynchronously.
  - Stock counters clear to 0; the system must restock after any reset.

Decomposition:
- Shared package (coin_pkg): coin values QUARTER_VALUE/DIME_VALUE/NICKEL_VALUE, money width 10, state encoding (2-bit IDLE=0, SELECT=1, EJECT=2, FINISH=3), coin-select enum (NONE, Q, D, N).
- The same package constants are to be used by the coin accumulator so both ends agree on coin values.
- One natural sub-module, coin_select: purely combinational.
  - Inputs: remaining, stockQ/D/N.
  - Outputs: selected coin and its value.
  - Keeps the priority logic isolated and separately testable.
- FSM, remaining register and stock counters stay in coin_dispenser.

Test Plan:
- Restock Q=D=N=10; start amount=65; coin_ack one cycle after each out* rise -> eject order Q,Q,D,N; done with shortfall=0; stock Q=8, D=9, N=9.
- Restock Q=1, D=3, N=0; amount=30 -> Q only, then done with shortfall=5 (greedy, not D,D,D); stockQ=0, stockD=3.
- Restock all 5; amount=7 -> single N; done with shortfall=2. Separately, amount=0 -> no out*; done in cycle 2; shortfall=0.
- Restock all 5; amount=25; hold coin_ack low 6 cycles -> outQ stays high all 6 cycles, no second coin. Pulse start/restock during EJECT -> ignored; stock unchanged except the Q decrement on ack.
- Restock all 5; amount=50; assert rst low while outQ high -> outQ falls without a clock edge; busy=0; stocks=0; shortfall=0. After release, start amount=50 -> immediate done with shortfall=50.
- coin_ack pulsed while IDLE, with no start -> no state change, stock and outputs unchanged.

Source files
------------

// File: rtl/coin_pkg.sv
// Shared coin definitions for the vending datapath: coin values, money width,
// dispenser state encoding and coin-select codes used by accumulator and dispenser.
package coin_pkg;

    localparam int MONEY_W       = 10;
    localparam int QUARTER_VALUE = 25;
    localparam int DIME_VALUE    = 10;
    localparam int NICKEL_VALUE  = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_EJECT  = 2'd2,
        ST_FINISH = 2'd3
    } disp_state_e;

    typedef enum logic [1:0] {
        COIN_NONE = 2'd0,
        COIN_Q    = 2'd1,
        COIN_D    = 2'd2,
        COIN_N    = 2'd3
    } coin_e;

endpackage

// File: rtl/coin_select.sv
// Greedy coin chooser: largest coin that fits the remaining amount and is in stock.
// Purely combinational so the priority rules can be exercised on their own.
module coin_select
    import coin_pkg::*;
#(
    parameter int STOCK_W = 8
) (
    input  logic [MONEY_W-1:0] remaining,
    input  logic [STOCK_W-1:0] stockQ,
    input  logic [STOCK_W-1:0] stockD,
    input  logic [STOCK_W-1:0] stockN,
    output coin_e              sel_coin,
    output logic [MONEY_W-1:0] sel_value
);

    always_comb begin
        sel_coin  = COIN_NONE;
        sel_value = '0;
        if (remaining >= MONEY_W'(QUARTER_VALUE) && stockQ != '0) begin
            sel_coin  = COIN_Q;
            sel_value = MONEY_W'(QUARTER_VALUE);
        end else if (remaining >= MONEY_W'(DIME_VALUE) && stockD != '0) begin
            sel_coin  = COIN_D;
            sel_value = MONEY_W'(DIME_VALUE);
        end else if (remaining >= MONEY_W'(NICKEL_VALUE) && stockN != '0) begin
            sel_coin  = COIN_N;
            sel_value = MONEY_W'(NICKEL_VALUE);
        end
    end

endmodule

// File: rtl/coin_dispenser.sv
// Change-return dispenser: pays a cents amount as individual coin ejects, greedy
// and stock-limited, one coin per eject handshake; unpaid cents go to shortfall.
module coin_dispenser
    import coin_pkg::*;
#(
    parameter int STOCK_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [MONEY_W-1:0] amount,
    input  logic               restock,
    input  logic [STOCK_W-1:0] stockQ_in,
    input  logic [STOCK_W-1:0] stockD_in,
    input  logic [STOCK_W-1:0] stockN_in,
    input  logic               coin_ack,
    output logic               outQ,
    output logic               outD,
    output logic               outN,
    output logic               busy,
    output logic               done,
    output logic [MONEY_W-1:0] shortfall,
    output logic [STOCK_W-1:0] stockQ,
    output logic [STOCK_W-1:0] stockD,
    output logic [STOCK_W-1:0] stockN,
    output disp_state_e        dbg_state
);

    // Eject handshake: an out* line is a level request that stays high until
    // coin_ack is sampled high on a rising edge; that edge completes the coin.

    disp_state_e        state_q, state_d;
    logic [MONEY_W-1:0] remaining_q, remaining_d;
    logic [MONEY_W-1:0] eject_value_q, eject_value_d;
    logic [MONEY_W-1:0] shortfall_q, shortfall_d;
    logic [STOCK_W-1:0] stockQ_q, stockQ_d;
    logic [STOCK_W-1:0] stockD_q, stockD_d;
    logic [STOCK_W-1:0] stockN_q, stockN_d;
    logic               outQ_q, outQ_d;
    logic               outD_q, outD_d;
    logic               outN_q, outN_d;

    coin_e              sel_coin;
    logic [MONEY_W-1:0] sel_value;

    coin_select #(.STOCK_W(STOCK_W)) u_coin_select (
        .remaining (remaining_q),
        .stockQ    (stockQ_q),
        .stockD    (stockD_q),
        .stockN    (stockN_q),
        .sel_coin  (sel_coin),
        .sel_value (sel_value)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            remaining_q   <= '0;
            eject_value_q <= '0;
            shortfall_q   <= '0;
            stockQ_q      <= '0;
            stockD_q      <= '0;
            stockN_q      <= '0;
            outQ_q        <= 1'b0;
            outD_q        <= 1'b0;
            outN_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            remaining_q   <= remaining_d;
            eject_value_q <= eject_value_d;
            shortfall_q   <= shortfall_d;
            stockQ_q      <= stockQ_d;
            stockD_q      <= stockD_d;
            stockN_q      <= stockN_d;
            outQ_q        <= outQ_d;
            outD_q        <= outD_d;
            outN_q        <= outN_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        remaining_d   = remaining_q;
        eject_value_d = eject_value_q;
        shortfall_d   = shortfall_q;
        stockQ_d      = stockQ_q;
        stockD_d      = stockD_q;
        stockN_d      = stockN_q;
        outQ_d        = outQ_q;
        outD_d        = outD_q;
        outN_d        = outN_q;
        case (state_q)
            ST_IDLE: begin
                if (restock) begin
                    stockQ_d = stockQ_in;
                    stockD_d = stockD_in;
                    stockN_d = stockN_in;
                end
                if (start) begin
                    remaining_d = amount;
                    state_d     = ST_SELECT;
                end
            end
            ST_SELECT: begin
                eject_value_d = sel_value;
                state_d       = ST_EJECT;
                case (sel_coin)
                    COIN_Q:  outQ_d = 1'b1;
                    COIN_D:  outD_d = 1'b1;
                    COIN_N:  outN_d = 1'b1;
                    default: begin
                        // shortfall is loaded here so it is already valid while done is high
                        shortfall_d = remaining_q;
                        state_d     = ST_FINISH;
                    end
                endcase
            end
            ST_EJECT: begin
                if (coin_ack) begin
                    remaining_d = remaining_q - eject_value_q;
                    if (outQ_q) stockQ_d = stockQ_q - STOCK_W'(1);
                    if (outD_q) stockD_d = stockD_q - STOCK_W'(1);
                    if (outN_q) stockN_d = stockN_q - STOCK_W'(1);
                    outQ_d  = 1'b0;
                    outD_d  = 1'b0;
                    outN_d  = 1'b0;
                    state_d = ST_SELECT;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign outQ      = outQ_q;
    assign outD      = outD_q;
    assign outN      = outN_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_FINISH);
    assign shortfall = shortfall_q;
    assign stockQ    = stockQ_q;
    assign stockD    = stockD_q;
    assign stockN    = stockN_q;
    assign dbg_state = state_q;

endmodule
